// File: rtl/fp_pkg.sv
// Shared types and constants for the 13-bit {sign, exp[3:0], frac[7:0]} float format.
package fp_pkg;

    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [7:0] frac;
    } fp13_t;

    localparam logic [3:0] FP_EXP_MAX  = 4'd15;
    localparam logic [7:0] FP_FRAC_MAX = 8'hFF;

endpackage

// File: rtl/fp_add_core.sv
// Combinational 13-bit float adder: align, add/subtract, renormalise.
module fp_add_core
    import fp_pkg::*;
(
    input  logic [12:0] op1_i,
    input  logic [12:0] op2_i,
    output logic [12:0] res_o,
    output logic        carry_out
);

    fp13_t      a, b, big, sml, res;
    logic [3:0] shamt;
    logic [7:0] shifted;
    logic [8:0] sum;
    logic [2:0] lead0;

    always_comb begin
        a = fp13_t'(op1_i);
        b = fp13_t'(op2_i);
        // Ties go to operand 2 so the result sign is deterministic on cancellation.
        if ({a.exp, a.frac} > {b.exp, b.frac}) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        shamt   = big.exp - sml.exp;
        shifted = (shamt >= 4'd8) ? 8'd0 : (sml.frac >> shamt);
        if (big.sign == sml.sign) sum = {1'b0, big.frac} + {1'b0, shifted};
        else                      sum = {1'b0, big.frac} - {1'b0, shifted};

        // Scan upward so the highest set bit of sum[7:1] decides the count.
        lead0 = 3'd7;
        for (int i = 0; i < 7; i++)
            if (sum[1+i]) lead0 = 3'(6 - i);

        res      = '0;
        res.sign = big.sign;
        if (sum[8]) begin
            res.exp  = big.exp + 4'd1;
            res.frac = sum[8:1];
        end else if (sum == 9'd0 || {1'b0, lead0} > big.exp) begin
            res.exp  = 4'd0;
            res.frac = 8'd0;
        end else begin
            res.exp  = big.exp - {1'b0, lead0};
            res.frac = sum[7:0] << lead0;
        end
        res_o     = res;
        carry_out = sum[8];
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fp_add_core among N_REQ requesters,
// with a single registered result slot under valid/ready backpressure.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ-1:0]   req_sign1,
    input  logic [N_REQ-1:0]   req_sign2,
    input  logic [4*N_REQ-1:0] req_exp1,
    input  logic [4*N_REQ-1:0] req_exp2,
    input  logic [8*N_REQ-1:0] req_frac1,
    input  logic [8*N_REQ-1:0] req_frac2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_sign,
    output logic [3:0]         rsp_exp,
    output logic [7:0]         rsp_frac,
    output logic               rsp_ovf
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    fp13_t           rsp_q, rsp_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            slot_free, gnt_found, gnt;
    logic [ID_W-1:0] gnt_idx;
    int unsigned     idx;
    fp13_t           op1, op2, core_res;
    logic            core_carry, ovf;

    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    assign gnt       = slot_free && gnt_found;
    assign req_ready = gnt ? (N_REQ'(1) << gnt_idx) : '0;

    assign op1 = '{sign: req_sign1[gnt_idx], exp: req_exp1[4*gnt_idx +: 4], frac: req_frac1[8*gnt_idx +: 8]};
    assign op2 = '{sign: req_sign2[gnt_idx], exp: req_exp2[4*gnt_idx +: 4], frac: req_frac2[8*gnt_idx +: 8]};

    fp_add_core u_core (
        .op1_i    (op1),
        .op2_i    (op2),
        .res_o    (core_res),
        .carry_out(core_carry)
    );

    // A carry yields exp_big+1, which wraps to 0 only when exp_big was 15.
    assign ovf = core_carry && (core_res.exp == 4'd0);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_d       = rsp_q;
        rsp_ovf_d   = rsp_ovf_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_ovf_d   = ovf;
            rsp_d       = ovf ? '{sign: core_res.sign, exp: FP_EXP_MAX, frac: FP_FRAC_MAX} : core_res;
            rr_ptr_d    = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
            rsp_ovf_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q       <= rsp_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sign  = rsp_q.sign;
    assign rsp_exp   = rsp_q.exp;
    assign rsp_frac  = rsp_q.frac;
    assign rsp_ovf   = rsp_ovf_q;

endmodule
